nn_layer_engine: RTL



---
 rtl/nn_pkg.sv | 59 +++++
 rtl/nn_layer_engine_mac.sv | 59 +++++
 rtl/nn_layer_engine.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared types and helpers for the fully-connected layer engine.
// Holds the phase and FSM state encodings, the weight-ROM base addresses
// of each layer, and the shift-and-saturate helper used to turn an
// accumulator into a DW-bit fixed-point activation.
package nn_pkg;

    typedef enum logic [2:0] {
        PH_NONE,
        PH_LOAD,
        PH_L1,
        PH_L2,
        PH_OUT
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Layer 1 weights start at the bottom of the ROM.
    function automatic int l1_base();
        return 0;
    endfunction

    // Layer 2 weights follow the N_HID x N_IN block of layer 1.
    function automatic int l2_base(input int n_in, input int n_hid);
        return n_hid * n_in;
    endfunction

    // Output-layer weights follow the N_HID x N_HID block of layer 2.
    function automatic int out_base(input int n_in, input int n_hid);
        return n_hid * n_in + n_hid * n_hid;
    endfunction

    // Arithmetic right shift by frac, then clamp to the signed dw-bit range.
    // Works on a 64-bit container so any accumulator width fits; callers
    // keep the low dw bits.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int dw,
                                                     input int frac);
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = acc >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sh > hi) begin
            sat_shift = hi;
        end else if (sh < lo) begin
            sat_shift = lo;
        end else begin
            sat_shift = sh;
        end
    endfunction

endpackage

// File: rtl/nn_layer_engine_mac.sv
// nn_mac_sat: serial multiply-accumulate with clear, plus the rounding
// stage that turns the accumulator into a DW-bit activation.
// Build option: define NN_ENGINE_RELU_EN to clamp negative hidden-layer
// results to zero (relu input high); otherwise relu is ignored.
module nn_mac_sat
    import nn_pkg::*;
#(
    parameter int DW    = 8,
    parameter int FRAC  = 4,
    parameter int ACC_W = 2 * DW + 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 acc_en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic                 relu,
    output logic signed [DW-1:0] res
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc_p2;
    logic signed [63:0]      sat;
    logic [63-DW:0]          unused_sat_hi;

    assign prod = a * b;

    // Accumulator: cleared between neurons, adds one sign-extended product per enabled cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_p2 <= '0;
        end else if (acc_en) begin
            acc_p2 <= acc_p2 + {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
        end
    end

    // ---- rounding stage: shift out fraction bits and saturate ----
    assign sat           = sat_shift({{(64 - ACC_W){acc_p2[ACC_W-1]}}, acc_p2}, DW, FRAC);
    assign unused_sat_hi = sat[63:DW];

`ifdef NN_ENGINE_RELU_EN
    // Activation: negative hidden results become zero.
    always_comb begin
        res = sat[DW-1:0];
        if (relu && sat[DW-1]) begin
            res = '0;
        end
    end
`else
    logic unused_relu;
    assign unused_relu = relu;

    // Activation: identity, saturated value passes straight through.
    always_comb begin
        res = sat[DW-1:0];
    end
`endif

endmodule

// File: rtl/nn_layer_engine.sv
// nn_layer_engine: runs one fully-connected layer per controller phase as
// a serial MAC over an external synchronous weight ROM, holding the input
// sample, both hidden activation vectors and the output vector.
// Build option: NN_ENGINE_RELU_EN enables ReLU on the two hidden layers.
module nn_layer_engine
    import nn_pkg::*;
#(
    parameter int DW    = 8,
    parameter int FRAC  = 4,
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int AW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hidden,
    input  logic                  ld1,
    input  logic                  ld2,
    input  logic                  batch_done,
    input  logic                  done,
    input  logic [N_IN*DW-1:0]    x_in,
    output logic [AW-1:0]         w_addr,
    input  logic [DW-1:0]         w_data,
    output logic                  calculation_done,
    output logic                  busy,
    output logic [N_OUT*DW-1:0]   y_out,
    output logic                  y_valid
);

    localparam int CW    = 8;
    localparam int ACC_W = 2 * DW + 4;

    state_t                state_q, state_d;
    phase_t                phase_q, cmd;
    logic [CW-1:0]         idx_q, neuron_q, fanin_q, nneur_q;
    logic [CW-1:0]         idx_p1;
    logic                  vld_p1;
    logic                  last_word, last_neuron;
    logic signed [DW-1:0]  x_q     [N_IN];
    logic signed [DW-1:0]  h1_q    [N_HID];
    logic signed [DW-1:0]  h2_q    [N_HID];
    logic signed [DW-1:0]  y_stage [N_OUT];
    logic signed [DW-1:0]  src;
    logic signed [DW-1:0]  res;

    assign last_word   = (idx_q == fanin_q - CW'(1));
    assign last_neuron = (neuron_q == nneur_q - CW'(1));

    // Phase decode of the controller levels, highest priority first.
    always_comb begin
        cmd = PH_NONE;
        if (done) begin
            cmd = PH_NONE;
        end else if (batch_done) begin
            cmd = PH_LOAD;
        end else if (hidden && ld1) begin
            cmd = PH_L1;
        end else if (hidden && ld2) begin
            cmd = PH_L2;
        end else if (!hidden && !ld1 && !ld2) begin
            cmd = PH_OUT;
        end
    end

    // Next-state logic: commands only matter while idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd == PH_L1 || cmd == PH_L2 || cmd == PH_OUT) state_d = ST_RUN;
            ST_RUN:   if (last_word) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: state_d = last_neuron ? ST_DONE : ST_RUN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control registers: FSM, counters, address generator and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            phase_q          <= PH_NONE;
            idx_q            <= '0;
            neuron_q         <= '0;
            fanin_q          <= '0;
            nneur_q          <= '0;
            w_addr           <= '0;
            busy             <= 1'b0;
            calculation_done <= 1'b0;
            y_valid          <= 1'b0;
            vld_p1           <= 1'b0;
            idx_p1           <= '0;
        end else begin
            state_q          <= state_d;
            busy             <= (state_d != ST_IDLE);
            calculation_done <= (state_d == ST_DONE);
            y_valid          <= (state_d == ST_DONE) && (phase_q == PH_OUT);
            // ---- stage p1: word fetched last cycle is accumulated now ----
            vld_p1           <= (state_q == ST_RUN);
            idx_p1           <= idx_q;
            case (state_q)
                ST_IDLE: begin
                    idx_q    <= '0;
                    neuron_q <= '0;
                    if (state_d == ST_RUN) begin
                        phase_q <= cmd;
                        case (cmd)
                            PH_L1: begin
                                fanin_q <= CW'(N_IN);
                                nneur_q <= CW'(N_HID);
                                w_addr  <= AW'(l1_base());
                            end
                            PH_L2: begin
                                fanin_q <= CW'(N_HID);
                                nneur_q <= CW'(N_HID);
                                w_addr  <= AW'(l2_base(N_IN, N_HID));
                            end
                            default: begin
                                fanin_q <= CW'(N_HID);
                                nneur_q <= CW'(N_OUT);
                                w_addr  <= AW'(out_base(N_IN, N_HID));
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    // Weights of consecutive neurons are contiguous, so the
                    // address simply keeps counting across neuron boundaries.
                    idx_q  <= idx_q + CW'(1);
                    w_addr <= w_addr + AW'(1);
                end
                ST_WRITE: begin
                    idx_q    <= '0;
                    neuron_q <= neuron_q + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Operand select: activation element matching the word now on w_data.
    always_comb begin
        src = '0;
        case (phase_q)
            PH_L1: begin
                for (int k = 0; k < N_IN; k++) begin
                    if (idx_p1 == CW'(k)) src = x_q[k];
                end
            end
            PH_L2: begin
                for (int k = 0; k < N_HID; k++) begin
                    if (idx_p1 == CW'(k)) src = h1_q[k];
                end
            end
            PH_OUT: begin
                for (int k = 0; k < N_HID; k++) begin
                    if (idx_p1 == CW'(k)) src = h2_q[k];
                end
            end
            default: src = '0;
        endcase
    end

    nn_mac_sat #(
        .DW    (DW),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .clr    ((state_q == ST_IDLE) || (state_q == ST_WRITE)),
        .acc_en (vld_p1),
        .a      (src),
        .b      (w_data),
        .relu   (phase_q != PH_OUT),
        .res    (res)
    );

    // ---- stage p2: write-back of sample, activations and output vector ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_IN; k++) x_q[k] <= '0;
            for (int k = 0; k < N_HID; k++) begin
                h1_q[k] <= '0;
                h2_q[k] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) y_stage[k] <= '0;
            y_out <= '0;
        end else if (state_q == ST_IDLE && cmd == PH_LOAD) begin
            for (int k = 0; k < N_IN; k++) x_q[k] <= x_in[k*DW +: DW];
        end else if (state_q == ST_WRITE) begin
            case (phase_q)
                PH_L1: begin
                    for (int k = 0; k < N_HID; k++) begin
                        if (neuron_q == CW'(k)) h1_q[k] <= res;
                    end
                end
                PH_L2: begin
                    for (int k = 0; k < N_HID; k++) begin
                        if (neuron_q == CW'(k)) h2_q[k] <= res;
                    end
                end
                PH_OUT: begin
                    for (int k = 0; k < N_OUT; k++) begin
                        if (neuron_q == CW'(k)) y_stage[k] <= res;
                    end
                    // The visible vector changes only once the whole layer is done.
                    if (last_neuron) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            y_out[k*DW +: DW] <= (neuron_q == CW'(k)) ? res : y_stage[k];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
